// File: rtl/memtest_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : memtest_pass_sequencer
// Brief    : Avalon-MM programmed run controller issuing size/seed per pass
//            and tracking checker completion, compare errors and timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module memtest_pass_sequencer #(
    parameter logic [31:0] SEED_STEP = 32'h9E3779B9,
    parameter int          TO_WIDTH  = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [3:0]   avs_address,
    input  logic [31:0]  avs_writedata,
    output logic [31:0]  avs_readdata,
    output logic         aso_size_valid,
    output logic [31:0]  aso_size_data,
    input  logic         aso_size_ready,
    output logic         aso_seed_valid,
    output logic [127:0] aso_seed_data,
    input  logic         aso_seed_ready,
    input  logic         asi_chkdone_valid,
    input  logic         asi_comperr_valid,
    output logic         busy,
    output logic         irq
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_SIZE = 3'd1,
        S_SEND_SEED = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [3:0] c_ADDR_CTRL    = 4'd0;
    localparam logic [3:0] c_ADDR_STATUS  = 4'd1;
    localparam logic [3:0] c_ADDR_SIZE    = 4'd2;
    localparam logic [3:0] c_ADDR_PASSES  = 4'd3;
    localparam logic [3:0] c_ADDR_SEED0   = 4'd4;
    localparam logic [3:0] c_ADDR_SEED1   = 4'd5;
    localparam logic [3:0] c_ADDR_SEED2   = 4'd6;
    localparam logic [3:0] c_ADDR_SEED3   = 4'd7;
    localparam logic [3:0] c_ADDR_PASSCNT = 4'd8;
    localparam logic [3:0] c_ADDR_ERRCNT  = 4'd9;
    localparam logic [3:0] c_ADDR_TIMEOUT = 4'd10;

    state_t                r_state;
    state_t                w_state_next;

    // Software-visible configuration
    logic                  r_ctrl_soe;
    logic                  r_ctrl_irq_en;
    logic [31:0]           r_cfg_size;
    logic [31:0]           r_cfg_passes;
    logic [31:0]           r_cfg_seed [4];
    logic [TO_WIDTH-1:0]   r_cfg_timeout;

    // Working copies latched at start
    logic [31:0]           r_run_size;
    logic [31:0]           r_run_passes;
    logic [127:0]          r_run_seed;
    logic [TO_WIDTH-1:0]   r_run_timeout;

    logic                  r_done;
    logic                  r_err_seen;
    logic                  r_aborted;
    logic                  r_timeout;
    logic                  r_irq;
    logic                  r_pass_err;
    logic [31:0]           r_pass_count;
    logic [31:0]           r_err_count;
    logic [TO_WIDTH-1:0]   r_watchdog;
    logic [31:0]           r_readdata;

    logic                  w_busy;
    logic                  w_wr_ctrl;
    logic                  w_cfg_wr_en;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_w1c;
    logic                  w_xfer_size;
    logic                  w_xfer_seed;
    logic                  w_to_hit;
    logic                  w_pass_err_any;
    logic                  w_enter_size;
    logic                  w_err_inc;
    logic [31:0]           w_pass_count_inc;
    logic [31:0]           w_rdata;

    assign w_busy           = (r_state != S_IDLE);
    assign w_wr_ctrl        = avs_write && (avs_address == c_ADDR_CTRL);
    assign w_cfg_wr_en      = avs_write && !w_busy;
    assign w_start          = w_wr_ctrl && avs_writedata[0] && !w_busy;
    assign w_abort          = w_wr_ctrl && avs_writedata[1] && w_busy;
    assign w_w1c            = avs_write && (avs_address == c_ADDR_STATUS) && avs_writedata[1];
    assign w_xfer_size      = aso_size_valid && aso_size_ready;
    assign w_xfer_seed      = aso_seed_valid && aso_seed_ready;
    assign w_pass_count_inc = r_pass_count + 32'd1;
    assign w_pass_err_any   = r_pass_err || asi_comperr_valid;
    assign w_err_inc        = asi_comperr_valid && w_busy && (r_err_count != 32'hFFFF_FFFF);

    // chkdone in the expiry cycle takes precedence over the timeout
    assign w_to_hit = (r_state == S_WAIT_DONE) && !asi_chkdone_valid &&
                      (r_run_timeout != '0) &&
                      (r_watchdog == r_run_timeout - TO_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        aso_size_valid = 1'b0;
        aso_seed_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_next = S_SEND_SIZE;
            end
            S_SEND_SIZE: begin
                aso_size_valid = 1'b1;
                if (w_xfer_size) w_state_next = S_SEND_SEED;
            end
            S_SEND_SEED: begin
                aso_seed_valid = 1'b1;
                if (w_xfer_seed) w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (asi_chkdone_valid)  w_state_next = S_NEXT;
                else if (w_to_hit)      w_state_next = S_FINISH;
            end
            S_NEXT: begin
                if (r_ctrl_soe && w_pass_err_any)
                    w_state_next = S_FINISH;
                else if ((r_run_passes != 32'd0) && (w_pass_count_inc == r_run_passes))
                    w_state_next = S_FINISH;
                else
                    w_state_next = S_SEND_SIZE;
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_abort) w_state_next = S_FINISH;
    end

    assign w_enter_size = (w_state_next == S_SEND_SIZE) && (r_state != S_SEND_SIZE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_soe    <= 1'b0;
            r_ctrl_irq_en <= 1'b0;
            r_cfg_size    <= '0;
            r_cfg_passes  <= '0;
            r_cfg_timeout <= '0;
            for (int i = 0; i < 4; i++) r_cfg_seed[i] <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl_soe    <= avs_writedata[2];
                r_ctrl_irq_en <= avs_writedata[3];
            end
            if (w_cfg_wr_en) begin
                case (avs_address)
                    c_ADDR_SIZE:    r_cfg_size    <= avs_writedata;
                    c_ADDR_PASSES:  r_cfg_passes  <= avs_writedata;
                    c_ADDR_SEED0:   r_cfg_seed[0] <= avs_writedata;
                    c_ADDR_SEED1:   r_cfg_seed[1] <= avs_writedata;
                    c_ADDR_SEED2:   r_cfg_seed[2] <= avs_writedata;
                    c_ADDR_SEED3:   r_cfg_seed[3] <= avs_writedata;
                    c_ADDR_TIMEOUT: r_cfg_timeout <= TO_WIDTH'(avs_writedata);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_size    <= '0;
            r_run_passes  <= '0;
            r_run_seed    <= '0;
            r_run_timeout <= '0;
        end else if (w_start) begin
            r_run_size    <= r_cfg_size;
            r_run_passes  <= r_cfg_passes;
            r_run_seed    <= {r_cfg_seed[3], r_cfg_seed[2], r_cfg_seed[1], r_cfg_seed[0]};
            r_run_timeout <= r_cfg_timeout;
        end else if (r_state == S_NEXT) begin
            for (int l = 0; l < 4; l++)
                r_run_seed[l*32 +: 32] <= r_run_seed[l*32 +: 32] + SEED_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pass_count <= '0;
            r_err_count  <= '0;
            r_pass_err   <= 1'b0;
            r_watchdog   <= '0;
        end else begin
            if (w_start)                  r_pass_count <= '0;
            else if (r_state == S_NEXT)   r_pass_count <= w_pass_count_inc;

            if (w_start)        r_err_count <= '0;
            else if (w_err_inc) r_err_count <= r_err_count + 32'd1;

            if (w_enter_size)                         r_pass_err <= 1'b0;
            else if (asi_comperr_valid && w_busy)     r_pass_err <= 1'b1;

            if (r_state == S_SEND_SEED)       r_watchdog <= '0;
            else if (r_state == S_WAIT_DONE)  r_watchdog <= r_watchdog + TO_WIDTH'(1);
        end
    end

    // Status flags: start clears, hardware set beats software W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done     <= 1'b0;
            r_err_seen <= 1'b0;
            r_aborted  <= 1'b0;
            r_timeout  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_start)                  r_done <= 1'b0;
            else if (r_state == S_FINISH) r_done <= 1'b1;
            else if (w_w1c)               r_done <= 1'b0;

            if (w_start)                             r_err_seen <= 1'b0;
            else if (asi_comperr_valid && w_busy)    r_err_seen <= 1'b1;
            else if (w_w1c)                          r_err_seen <= 1'b0;

            if (w_start)                  r_aborted <= 1'b0;
            else if (w_abort || w_to_hit) r_aborted <= 1'b1;
            else if (w_w1c)               r_aborted <= 1'b0;

            if (w_start)                  r_timeout <= 1'b0;
            else if (w_to_hit && !w_abort) r_timeout <= 1'b1;
            else if (w_w1c)               r_timeout <= 1'b0;

            r_irq <= r_done && r_ctrl_irq_en;
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (avs_address)
            c_ADDR_CTRL:    w_rdata = {28'h0, r_ctrl_irq_en, r_ctrl_soe, 2'b00};
            c_ADDR_STATUS:  w_rdata = {21'h0, r_state, 3'b000, r_timeout, r_aborted,
                                       r_err_seen, r_done, w_busy};
            c_ADDR_SIZE:    w_rdata = r_cfg_size;
            c_ADDR_PASSES:  w_rdata = r_cfg_passes;
            c_ADDR_SEED0:   w_rdata = r_cfg_seed[0];
            c_ADDR_SEED1:   w_rdata = r_cfg_seed[1];
            c_ADDR_SEED2:   w_rdata = r_cfg_seed[2];
            c_ADDR_SEED3:   w_rdata = r_cfg_seed[3];
            c_ADDR_PASSCNT: w_rdata = r_pass_count;
            c_ADDR_ERRCNT:  w_rdata = r_err_count;
            c_ADDR_TIMEOUT: w_rdata = 32'(r_cfg_timeout);
            default:        w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs_readdata  = r_readdata;
    assign aso_size_data = r_run_size;
    assign aso_seed_data = r_run_seed;
    assign busy          = w_busy;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_memtest_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_memtest_pass_sequencer
// Brief    : Scenario bench for memtest_pass_sequencer with stream scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_memtest_pass_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         avs_read;
    logic         avs_write;
    logic [3:0]   avs_address;
    logic [31:0]  avs_writedata;
    logic [31:0]  avs_readdata;
    logic         aso_size_valid;
    logic [31:0]  aso_size_data;
    logic         aso_size_ready;
    logic         aso_seed_valid;
    logic [127:0] aso_seed_data;
    logic         aso_seed_ready;
    logic         asi_chkdone_valid;
    logic         asi_comperr_valid;
    logic         busy;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int chk_delay = -1;
    int cd = -1;
    logic [31:0]  exp_size_q [$];
    logic [127:0] exp_seed_q [$];
    logic [31:0]  mon_size;
    logic [127:0] mon_seed;

    localparam logic [127:0] c_SEED_A = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] c_SEED_B = 128'hDEADBEEF_01234567_FFFFFFF0_80000000;

    memtest_pass_sequencer u_dut (
        .clk               (clk),
        .reset             (reset),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_address       (avs_address),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .aso_size_valid    (aso_size_valid),
        .aso_size_data     (aso_size_data),
        .aso_size_ready    (aso_size_ready),
        .aso_seed_valid    (aso_seed_valid),
        .aso_seed_data     (aso_seed_data),
        .aso_seed_ready    (aso_seed_ready),
        .asi_chkdone_valid (asi_chkdone_valid),
        .asi_comperr_valid (asi_comperr_valid),
        .busy              (busy),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    // Stream monitor/scoreboard and checker-completion responder
    initial begin
        asi_chkdone_valid = 1'b0;
        forever begin
            @(negedge clk);
            asi_chkdone_valid = (cd == 1);
            if (cd > 0) cd = cd - 1;
            if (!reset && aso_size_valid && aso_size_ready) begin
                checks++;
                if (exp_size_q.size() == 0) begin
                    errors++;
                    $display("FAIL size_xfer unexpected: got %h required no transfer", aso_size_data);
                end else begin
                    mon_size = exp_size_q.pop_front();
                    if (aso_size_data !== mon_size) begin
                        errors++;
                        $display("FAIL size_xfer: got %h required %h", aso_size_data, mon_size);
                    end
                end
            end
            if (!reset && aso_seed_valid && aso_seed_ready) begin
                cd = chk_delay;
                checks++;
                if (exp_seed_q.size() == 0) begin
                    errors++;
                    $display("FAIL seed_xfer unexpected: got %h required no transfer", aso_seed_data);
                end else begin
                    mon_seed = exp_seed_q.pop_front();
                    if (aso_seed_data !== mon_seed) begin
                        errors++;
                        $display("FAIL seed_xfer: got %h required %h", aso_seed_data, mon_seed);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        avs_read = 1'b1; avs_address = a;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic program_run(input logic [31:0] size, input logic [127:0] seed,
                               input logic [31:0] passes, input logic [31:0] tmo);
        csr_wr(4'd2, size);
        csr_wr(4'd3, passes);
        for (int l = 0; l < 4; l++) csr_wr(4'(4 + l), seed[l*32 +: 32]);
        csr_wr(4'd10, tmo);
    endtask

    task automatic push_expected(input logic [31:0] size, input logic [127:0] seed, input int n);
        logic [127:0] s;
        s = seed;
        for (int p = 0; p < n; p++) begin
            exp_size_q.push_back(size);
            exp_seed_q.push_back(s);
            for (int l = 0; l < 4; l++) s[l*32 +: 32] = s[l*32 +: 32] + 32'h9E3779B9;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic wait_seed_xfer(input int budget);
        int n;
        n = 0;
        while (!(aso_seed_valid && aso_seed_ready) && n < budget) begin tick(); n++; end
        checks++;
        if (!(aso_seed_valid && aso_seed_ready)) begin
            errors++;
            $display("FAIL wait_seed_xfer: no seed handshake in %0d cycles, required one", n);
        end
    endtask

    task automatic check_queues(input string tag);
        checks++;
        if (exp_size_q.size() != 0 || exp_seed_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending: size_q=%0d seed_q=%0d required 0/0",
                     tag, exp_size_q.size(), exp_seed_q.size());
        end
        exp_size_q.delete();
        exp_seed_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({aso_size_valid, aso_seed_valid, busy, irq} !== 4'b0 || aso_size_data !== 32'h0 ||
            aso_seed_data !== 128'h0 || avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: sv=%b dv=%b busy=%b irq=%b required all 0",
                     aso_size_valid, aso_seed_valid, busy, irq);
        end
        reset = 1'b0;
        tick();
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required 0", d); end
        csr_rd(4'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h required 0", d); end
    endtask

    task automatic test_basic_run();
        logic [31:0] d;
        program_run(32'h1000, c_SEED_A, 32'd2, 32'd0);
        chk_delay = 20;
        push_expected(32'h1000, c_SEED_A, 2);
        csr_wr(4'd0, 32'h1);
        wait_idle(400);
        check_queues("basic");
        csr_rd(4'd8, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL basic_pass_count: got %0d required 2", d); end
        csr_rd(4'd9, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL basic_err_count: got %0d required 0", d); end
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL basic_status: got %h required 2", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq: got %b required 0", irq); end
    endtask

    task automatic test_backpressure();
        program_run(32'h2000, c_SEED_B, 32'd1, 32'd0);
        chk_delay = 5;
        push_expected(32'h2000, c_SEED_B, 1);
        aso_size_ready = 1'b0;
        csr_wr(4'd0, 32'h1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (aso_size_valid !== 1'b1 || aso_size_data !== 32'h2000 || aso_seed_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: sv=%b data=%h dv=%b required 1/00002000/0",
                         i, aso_size_valid, aso_size_data, aso_seed_valid);
            end
            tick();
        end
        aso_size_ready = 1'b1;
        wait_idle(200);
        check_queues("backpressure");
    endtask

    task automatic test_stop_on_error();
        logic [31:0] d;
        int hs;
        int n;
        program_run(32'h400, c_SEED_B, 32'd5, 32'd0);
        chk_delay = 20;
        push_expected(32'h400, c_SEED_B, 2);
        csr_wr(4'd0, 32'hD);
        hs = 0;
        n  = 0;
        while (hs < 2 && n < 300) begin
            if (aso_seed_valid && aso_seed_ready) hs++;
            if (hs < 2) begin tick(); n++; end
        end
        checks++;
        if (hs != 2) begin errors++; $display("FAIL soe_handshakes: got %0d required 2", hs); end
        tick(); tick(); tick();
        for (int k = 0; k < 3; k++) begin
            asi_comperr_valid = 1'b1; tick();
            asi_comperr_valid = 1'b0; tick();
        end
        wait_idle(200);
        check_queues("stop_on_error");
        csr_rd(4'd8, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL soe_pass_count: got %0d required 2", d); end
        csr_rd(4'd9, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL soe_err_count: got %0d required 3", d); end
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL soe_status: got %h required 6", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL soe_irq: got %b required 1", irq); end
        csr_wr(4'd1, 32'h2);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int n;
        program_run(32'h800, c_SEED_A, 32'd1, 32'd50);
        chk_delay = -1;
        push_expected(32'h800, c_SEED_A, 1);
        csr_wr(4'd0, 32'h9);
        wait_seed_xfer(50);
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        checks++;
        if (n != 52) begin errors++; $display("FAIL timeout_latency: idle after %0d cycles required 52", n); end
        check_queues("timeout");
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'h1A) begin errors++; $display("FAIL timeout_status: got %h required 1a", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL timeout_irq: got %b required 1", irq); end
        csr_wr(4'd1, 32'h2);
        tick(); tick();
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL w1c_status: got %h required 0", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b required 0", irq); end
        csr_wr(4'd10, 32'd0);
    endtask

    task automatic test_abort();
        logic [31:0] d;
        program_run(32'h3000, c_SEED_B, 32'd0, 32'd0);
        chk_delay = -1;
        push_expected(32'h3000, c_SEED_B, 1);
        csr_wr(4'd0, 32'h1);
        wait_seed_xfer(50);
        tick(); tick();
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'h301) begin errors++; $display("FAIL abort_busy_status: got %h required 301", d); end
        csr_wr(4'd2, 32'h55);
        csr_wr(4'd0, 32'h1);
        tick(); tick();
        csr_wr(4'd0, 32'hA);
        wait_idle(20);
        check_queues("abort");
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'hA) begin errors++; $display("FAIL abort_status: got %h required a", d); end
        csr_rd(4'd2, d);
        checks++;
        if (d !== 32'h3000) begin errors++; $display("FAIL abort_size_locked: got %h required 3000", d); end
        csr_rd(4'd8, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL abort_pass_count: got %0d required 0", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL abort_irq: got %b required 1", irq); end
        csr_wr(4'd3, 32'd1);
        chk_delay = 20;
        push_expected(32'h3000, c_SEED_B, 1);
        csr_wr(4'd0, 32'h1);
        wait_idle(200);
        check_queues("restart");
        csr_rd(4'd8, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL restart_pass_count: got %0d required 1", d); end
        csr_rd(4'd1, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL restart_status: got %h required 2", d); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        int n;
        program_run(32'h100, c_SEED_A, 32'd1, 32'd0);
        chk_delay = -1;
        push_expected(32'h100, c_SEED_A, 1);
        aso_seed_ready = 1'b0;
        csr_wr(4'd0, 32'h9);
        n = 0;
        while (!aso_seed_valid && n < 50) begin tick(); n++; end
        checks++;
        if (aso_seed_valid !== 1'b1) begin errors++; $display("FAIL mid_reach_seed: dv=%b required 1", aso_seed_valid); end
        reset = 1'b1;
        #1;
        checks++;
        if ({aso_size_valid, aso_seed_valid, busy, irq} !== 4'b0 || aso_size_data !== 32'h0 ||
            aso_seed_data !== 128'h0 || avs_readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: sv=%b dv=%b busy=%b irq=%b required all 0",
                     aso_size_valid, aso_seed_valid, busy, irq);
        end
        tick(); tick();
        reset = 1'b0;
        aso_seed_ready = 1'b1;
        exp_seed_q.delete();
        tick();
        check_queues("reset_mid");
        for (int a = 0; a < 16; a++) begin
            csr_rd(4'(a), d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL post_reset_csr%0d: got %h required 0", a, d); end
        end
    endtask

    initial begin
        reset = 1'b1;
        avs_read = 1'b0; avs_write = 1'b0; avs_address = 4'd0; avs_writedata = 32'h0;
        aso_size_ready = 1'b1; aso_seed_ready = 1'b1; asi_comperr_valid = 1'b0;
        tick();
        test_reset();
        test_basic_run();
        test_backpressure();
        test_stop_on_error();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memtest_pass_sequencer.md
Name: memtest_pass_sequencer

Overview:
Autonomous run controller for the memory-test datapath. Software programs size, base seed, pass count and timeout over Avalon-MM, then writes start. The block then performs N generate/check passes. Each pass presents size and seed to the data generator over valid/ready streams, waits for the checker's completion pulse, and counts compare errors. It advances the seed between passes and raises an interrupt on completion, error stop, abort or timeout.

Parameters:
SEED_STEP, 32'h9E3779B9, value added (mod 2^32) to each 32-bit seed lane after every pass
TO_WIDTH, 32, width of the per-pass watchdog counter and TIMEOUT register

Ports:
clk  in  1  clock
reset  in  1  reset
avs_read  in  1  CSR read strobe
avs_write  in  1  CSR write strobe
avs_address  in  4  CSR word address
avs_writedata  in  32  CSR write data
avs_readdata  out  32  CSR read data, registered, latency 1
aso_size_valid  out  1  size stream valid
aso_size_data  out  32  transfer size in bytes
aso_size_ready  in  1  size stream ready
aso_seed_valid  out  1  seed stream valid
aso_seed_data  out  128  current pass seed
aso_seed_ready  in  1  seed stream ready
asi_chkdone_valid  in  1  one-cycle pulse: checker finished current pass
asi_comperr_valid  in  1  one-cycle pulse per miscompared beat
busy  out  1  run in progress
irq  out  1  level interrupt

Behaviour:
- Interface: reset is asynchronous, active-high; clk is the clock. All state is reset asynchronously.
- Output reset values: all outputs 0; aso_seed_data/aso_size_data 0.
- CSR map:
  - 0 CTRL (W): b0 start (self-clearing); b1 abort (self-clearing); b2 stop_on_error; b3 irq_en. Reads return {28'h0, b3, b2, 2'b00}.
  - 1 STATUS: b0 busy; b1 done; b2 err_seen; b3 aborted; b4 timeout; [10:8] fsm state. Writing 1 to b1 clears b1–b4 and irq.
  - 2 SIZE, 3 PASSES (0 = run until abort/error stop), 4–7 SEED lanes 0–3, 10 TIMEOUT (0 = disabled). All R/W.
  - 8 PASS_COUNT and 9 ERR_COUNT are read-only. Unmapped reads return 0.
- Writes to 2–7 and 10 while busy=1 are ignored; the run uses copies latched at start.
- Start while busy is ignored. Start when idle:
  - latch working copies;
  - clear PASS_COUNT, ERR_COUNT, done, err_seen, aborted, timeout;
  - enter SEND_SIZE on the next cycle.
- FSM: IDLE(0), SEND_SIZE(1), SEND_SEED(2), WAIT_DONE(3), NEXT(4), FINISH(5).
  - SEND_SIZE: size_valid=1, data stable until ready. Transfer occurs on the cycle valid&ready -> SEND_SEED.
  - SEND_SEED: same handshake on the seed stream -> WAIT_DONE; watchdog cleared.
  - WAIT_DONE: watchdog increments each cycle. chkdone pulse -> NEXT. If TIMEOUT≠0 and watchdog==TIMEOUT-1 without chkdone, set timeout and aborted -> FINISH. chkdone in the same cycle as expiry wins (-> NEXT).
  - NEXT (1 cycle): PASS_COUNT+1; each seed lane += SEED_STEP. If stop_on_error and an error occurred this pass -> FINISH. Else if PASSES≠0 and new PASS_COUNT==PASSES -> FINISH. Else -> SEND_SIZE.
  - FINISH (1 cycle): set done; irq=irq_en; -> IDLE.
- busy=1 in every state except IDLE.
- ERR_COUNT increments on every comperr pulse while busy, saturating at 32'hFFFFFFFF. Any pulse sets err_seen and the per-pass error flag. The per-pass flag clears on entry to SEND_SIZE.
- Abort while busy: all valids deassert next cycle; set aborted -> FINISH. Abort has priority over every other transition. Abort when idle has no effect.
- W1C of done in the same cycle FINISH sets done: the set wins.
- irq = done & irq_en, registered. Clearing irq_en deasserts irq without clearing done.
- PASS_COUNT wraps mod 2^32 when PASSES=0.
- Reset mid-run returns to IDLE, drops valids immediately and clears all CSRs.

Test Plan:
1. SIZE=0x1000, SEED={4,3,2,1}, PASSES=2, ready tied 1, chkdone 20 cycles after seed accept.
   -> two size/seed handshakes; second seed lanes = lane+0x9E3779B9; PASS_COUNT=2; done=1; busy low.
2. Size ready held low 10 cycles.
   -> size_valid and data stable for all 10 cycles; single transfer; seed_valid is not raised before the size transfer.
3. stop_on_error=1, PASSES=5, 3 comperr pulses in pass 2.
   -> stops after pass 2; PASS_COUNT=2; ERR_COUNT=3; err_seen=1; irq=1 with irq_en.
4. TIMEOUT=50, chkdone never arrives.
   -> FINISH 50 cycles after seed accept; timeout=1, aborted=1. Then W1C STATUS=0x2 -> STATUS bits 1–4 clear, irq=0.
5. PASSES=0 with abort written in WAIT_DONE; also a SIZE write while busy.
   -> aborted=1; SIZE readback unchanged; start during busy ignored; a later start runs normally.
6. Assert reset during SEND_SEED.
   -> all outputs 0 immediately, STATUS=0; post-reset CSR reads all 0.
